// File: rtl/physics_pkg.sv
// Shared definitions for the physics sequencer: FSM state encoding,
// position field layout, counter width and default blast-zone bounds.
package physics_pkg;

    // Sequencer states; values are visible on state_out.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_KNOCKBACK = 2'd1,
        ST_HITSTUN   = 2'd2,
        ST_RESPAWN   = 2'd3
    } phys_state_e;

    // Position word layout: x in the upper half, y in the lower half.
    localparam int POS_W = 16;
    localparam int CNT_W = 18;

    typedef struct packed {
        logic signed [POS_W-1:0] x;
        logic signed [POS_W-1:0] y;
    } pos_t;

    // Default blast zone; a coordinate equal to a bound is still in play.
    localparam logic signed [POS_W-1:0] DEF_BLAST_LEFT   = -16'sd200;
    localparam logic signed [POS_W-1:0] DEF_BLAST_RIGHT  = 16'sd840;
    localparam logic signed [POS_W-1:0] DEF_BLAST_BOTTOM = -16'sd200;
    localparam logic signed [POS_W-1:0] DEF_BLAST_TOP    = 16'sd680;

    // Strictly outside [lo, hi] using signed compares.
    function automatic logic out_of_range(
        input logic signed [POS_W-1:0] v,
        input logic signed [POS_W-1:0] lo,
        input logic signed [POS_W-1:0] hi
    );
        return (v < lo) || (v > hi);
    endfunction

endpackage

// File: rtl/phys_seq_bounds.sv
// Combinational blast-zone check: raises oob when the player position
// lies strictly outside any of the four bounds.
module phys_seq_bounds
    import physics_pkg::*;
#(
    parameter logic signed [POS_W-1:0] BLAST_LEFT   = DEF_BLAST_LEFT,
    parameter logic signed [POS_W-1:0] BLAST_RIGHT  = DEF_BLAST_RIGHT,
    parameter logic signed [POS_W-1:0] BLAST_BOTTOM = DEF_BLAST_BOTTOM,
    parameter logic signed [POS_W-1:0] BLAST_TOP    = DEF_BLAST_TOP
) (
    input  logic [2*POS_W-1:0] position,
    output logic               oob
);

    pos_t pos_s;

    // Split the position word and compare each axis against its bounds
    always_comb begin
        pos_s = position;
        oob   = out_of_range(pos_s.x, BLAST_LEFT, BLAST_RIGHT) |
                out_of_range(pos_s.y, BLAST_BOTTOM, BLAST_TOP);
    end

endmodule

// File: rtl/physics_sequencer.sv
// Hit / knockback / hitstun / respawn sequencer driving the physics block.
// One shared down-counter times every window; all outputs are registered
// from the next-state decode so they line up with state_out.
// Optional feature macro: PHYS_SEQ_INVULN_EN adds a post-respawn
// invulnerability window during which hits are ignored.
module physics_sequencer
    import physics_pkg::*;
#(
    parameter int                      KB_CYCLES      = 2048,
    parameter int                      HITSTUN_CYCLES = 65536,
    parameter int                      RESPAWN_CYCLES = 16,
    parameter logic signed [POS_W-1:0] BLAST_LEFT     = DEF_BLAST_LEFT,
    parameter logic signed [POS_W-1:0] BLAST_RIGHT    = DEF_BLAST_RIGHT,
    parameter logic signed [POS_W-1:0] BLAST_BOTTOM   = DEF_BLAST_BOTTOM,
    parameter logic signed [POS_W-1:0] BLAST_TOP      = DEF_BLAST_TOP,
    parameter int                      INVULN_CYCLES  = 131072
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hit_valid,
    input  logic [2*POS_W-1:0] position,
    input  logic               freeze_req,
    output logic               attack_out,
    output logic               freeze_out,
    output logic               phys_reset,
    output logic               ko_pulse,
    output logic [1:0]         state_out,
    output logic               invuln_out
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] KB_LOAD  = CNT_W'(KB_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] HS_LOAD  = CNT_W'(HITSTUN_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] RS_LOAD  = CNT_W'(RESPAWN_CYCLES - 32'sd1);

    // Every window length must fit the 18-bit counter and be non-empty
    if (KB_CYCLES < 32'sd1 || KB_CYCLES > 32'sd262144 ||
        HITSTUN_CYCLES < 32'sd1 || HITSTUN_CYCLES > 32'sd262144 ||
        RESPAWN_CYCLES < 32'sd1 || RESPAWN_CYCLES > 32'sd262144 ||
        INVULN_CYCLES < 32'sd1 || INVULN_CYCLES > 32'sd262144) begin : g_bad_cfg
        $error("physics_sequencer: cycle parameter out of range");
    end

    phys_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             attack_q, attack_d;
    logic             freeze_q, freeze_d;
    logic             preset_q, preset_d;
    logic             ko_q, ko_d;
    logic             oob_s;
    logic             hit_s;

    phys_seq_bounds #(
        .BLAST_LEFT   (BLAST_LEFT),
        .BLAST_RIGHT  (BLAST_RIGHT),
        .BLAST_BOTTOM (BLAST_BOTTOM),
        .BLAST_TOP    (BLAST_TOP)
    ) u_bounds (
        .position (position),
        .oob      (oob_s)
    );

`ifdef PHYS_SEQ_INVULN_EN
    localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_CYCLES - 32'sd1);

    logic [CNT_W-1:0] inv_q, inv_d;
    logic             invuln_q, invuln_d;

    // Arm invulnerability on respawn exit, count it down, and mask hits meanwhile
    always_comb begin
        inv_d = inv_q;
        if (state_q == ST_RESPAWN && cnt_q == CNT_ZERO) begin
            inv_d = INV_LOAD;
        end else if (inv_q != CNT_ZERO) begin
            inv_d = inv_q - CNT_ONE;
        end else begin
            inv_d = inv_q;
        end
        invuln_d = (inv_d != CNT_ZERO);
        hit_s    = hit_valid & (inv_q == CNT_ZERO);
    end

    // Invulnerability counter and its registered flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inv_q    <= CNT_ZERO;
            invuln_q <= 1'b0;
        end else begin
            inv_q    <= inv_d;
            invuln_q <= invuln_d;
        end
    end

    assign invuln_out = invuln_q;
`else
    // Hits are always accepted when there is no invulnerability window
    always_comb begin
        hit_s = hit_valid;
    end

    assign invuln_out = 1'b0;
`endif

    // Next state / counter; oob outranks hits everywhere except RESPAWN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (oob_s) begin
                    state_d = ST_RESPAWN;
                    cnt_d   = RS_LOAD;
                end else if (hit_s) begin
                    state_d = ST_KNOCKBACK;
                    cnt_d   = KB_LOAD;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_KNOCKBACK: begin
                if (oob_s) begin
                    state_d = ST_RESPAWN;
                    cnt_d   = RS_LOAD;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HITSTUN;
                    cnt_d   = HS_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_HITSTUN: begin
                if (oob_s) begin
                    state_d = ST_RESPAWN;
                    cnt_d   = RS_LOAD;
                end else if (hit_s) begin
                    // Combo: a new knockback window, attack_out re-rises next cycle
                    state_d = ST_KNOCKBACK;
                    cnt_d   = KB_LOAD;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_RESPAWN: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        attack_d = (state_d == ST_KNOCKBACK);
        freeze_d = (state_d == ST_HITSTUN) | freeze_req;
        preset_d = (state_d == ST_RESPAWN);
        ko_d     = (state_d == ST_RESPAWN) && (state_q != ST_RESPAWN);
    end

    // State, shared counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            attack_q <= 1'b0;
            freeze_q <= 1'b0;
            preset_q <= 1'b0;
            ko_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            attack_q <= attack_d;
            freeze_q <= freeze_d;
            preset_q <= preset_d;
            ko_q     <= ko_d;
        end
    end

    assign attack_out = attack_q;
    assign freeze_out = freeze_q;
    assign phys_reset = preset_q;
    assign ko_pulse   = ko_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_physics_sequencer.sv
// Self-checking bench for physics_sequencer: directed scenarios followed by
// randomized traffic, all compared against a phase/remaining-cycles model.
`timescale 1ns/1ps
module tb_physics_sequencer;

    localparam int KB  = 4;
    localparam int HS  = 8;
    localparam int RS  = 3;
    localparam int INV = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hit_valid = 1'b0;
    logic        freeze_req = 1'b0;
    logic [31:0] position = 32'd0;
    logic        attack_out, freeze_out, phys_reset, ko_pulse, invuln_out;
    logic [1:0]  state_out;

    int errors = 0;
    int checks = 0;

    // Reference model: phase number, cycles left in phase, invulnerable cycles left
    int   m_ph, m_left, m_inv;
    logic [1:0] e_st;
    logic e_att, e_frz, e_rst, e_ko, e_inv;

    int rst_cnt, ko_cnt, wait_n;

    physics_sequencer #(
        .KB_CYCLES      (KB),
        .HITSTUN_CYCLES (HS),
        .RESPAWN_CYCLES (RS),
        .INVULN_CYCLES  (INV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .hit_valid  (hit_valid),
        .position   (position),
        .freeze_req (freeze_req),
        .attack_out (attack_out),
        .freeze_out (freeze_out),
        .phys_reset (phys_reset),
        .ko_pulse   (ko_pulse),
        .state_out  (state_out),
        .invuln_out (invuln_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pos(input int x, input int y);
        logic [15:0] xs, ys;
        xs = 16'(x);
        ys = 16'(y);
        return {xs, ys};
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        int x, y;
        bit oob, hit, exit_rs;
        x = $signed(position[31:16]);
        y = $signed(position[15:0]);
        oob = (x < -200) || (x > 840) || (y < -200) || (y > 680);
`ifdef PHYS_SEQ_INVULN_EN
        hit = hit_valid && (m_inv == 0);
`else
        hit = hit_valid;
`endif
        exit_rs = 1'b0;
        e_ko = 1'b0;
        if (m_ph != 3 && oob) begin
            m_ph = 3; m_left = RS; e_ko = 1'b1;
        end else if (m_ph == 0) begin
            if (hit) begin m_ph = 1; m_left = KB; end
        end else if (m_ph == 1) begin
            if (m_left == 1) begin m_ph = 2; m_left = HS; end
            else m_left--;
        end else if (m_ph == 2) begin
            if (hit) begin m_ph = 1; m_left = KB; end
            else if (m_left == 1) m_ph = 0;
            else m_left--;
        end else begin
            if (m_left == 1) begin m_ph = 0; exit_rs = 1'b1; end
            else m_left--;
        end
        if (exit_rs) m_inv = INV - 1;
        else if (m_inv > 0) m_inv--;
        e_st  = 2'(m_ph);
        e_att = (m_ph == 1);
        e_frz = (m_ph == 2) || freeze_req;
        e_rst = (m_ph == 3);
`ifdef PHYS_SEQ_INVULN_EN
        e_inv = (m_inv != 0);
`else
        e_inv = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
        chk("state_out", state_out, e_st);
        chk("attack_out", attack_out, e_att);
        chk("freeze_out", freeze_out, e_frz);
        chk("phys_reset", phys_reset, e_rst);
        chk("ko_pulse", ko_pulse, e_ko);
        chk("invuln_out", invuln_out, e_inv);
    endtask

    // Assert reset between edges, check outputs clear at once, release on negedge
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        m_ph = 0; m_left = 0; m_inv = 0;
        chk("rst_state", state_out, 2'd0);
        chk("rst_attack", attack_out, 1'b0);
        chk("rst_freeze", freeze_out, 1'b0);
        chk("rst_phys_reset", phys_reset, 1'b0);
        chk("rst_ko", ko_pulse, 1'b0);
        chk("rst_invuln", invuln_out, 1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Knockback then hitstun window after a hit sampled on the previous tick
    task automatic check_window(input string tag);
        for (int i = 1; i <= 13; i++) begin
            if (i > 1) tick();
            chk({tag, "_attack"}, attack_out, 2'(i <= KB));
            chk({tag, "_freeze"}, freeze_out, 2'(i > KB && i <= KB + HS));
        end
        chk({tag, "_end_state"}, state_out, 2'd0);
    endtask

    initial begin
        position = pos(100, 100);
        do_reset();
        tick();
        tick();

        // Single hit: attack t1..t4, freeze t5..t12, idle at t13
        hit_valid = 1'b1; tick(); hit_valid = 1'b0;
        check_window("hit");
        tick();

        // Combo in hitstun cycle 3
        hit_valid = 1'b1; tick(); hit_valid = 1'b0;
        for (int i = 0; i < KB + 2; i++) tick();
        chk("combo_pre_state", state_out, 2'd2);
        chk("combo_pre_attack", attack_out, 1'b0);
        hit_valid = 1'b1; tick(); hit_valid = 1'b0;
        check_window("combo");
        tick();

        // x = -201 in IDLE: three cycles of phys_reset, one ko on the first
        position = pos(-201, 100); tick(); position = pos(100, 100);
        chk("oob_first_ko", ko_pulse, 1'b1);
        rst_cnt = int'(phys_reset); ko_cnt = int'(ko_pulse);
        for (int i = 0; i < 5; i++) begin
            tick();
            rst_cnt += int'(phys_reset); ko_cnt += int'(ko_pulse);
        end
        chk("oob_reset_len", 2'(rst_cnt), 2'd3);
        chk("oob_ko_count", 2'(ko_cnt), 2'd1);

        // Bounds equal to the limit stay in play
        position = pos(-200, 100);
        for (int i = 0; i < 3; i++) tick();
        chk("edge_x_state", state_out, 2'd0);
        position = pos(100, 680);
        for (int i = 0; i < 3; i++) tick();
        chk("edge_y_reset", phys_reset, 1'b0);
        // Hit together with y=681: respawn wins
        position = pos(100, 681); hit_valid = 1'b1; tick(); hit_valid = 1'b0;
        position = pos(100, 100);
        chk("oob_vs_hit_state", state_out, 2'd3);
        chk("oob_vs_hit_attack", attack_out, 1'b0);
        for (int i = 0; i < 14; i++) tick();

`ifdef PHYS_SEQ_INVULN_EN
        // Hit 5 cycles after respawn exit is ignored, at 11 cycles it lands
        position = pos(-201, 100); tick(); position = pos(100, 100);
        wait_n = 0;
        while (state_out != 2'd0 && wait_n < 20) begin tick(); wait_n++; end
        chk("inv_exit_state", state_out, 2'd0);
        for (int i = 0; i < 4; i++) tick();
        hit_valid = 1'b1; tick(); hit_valid = 1'b0;
        chk("inv_hit_ignored", state_out, 2'd0);
        chk("inv_flag", invuln_out, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        hit_valid = 1'b1; tick(); hit_valid = 1'b0;
        chk("inv_hit_taken", state_out, 2'd1);
        for (int i = 0; i < 14; i++) tick();
`endif

        // Reset during knockback cycle 2 aborts with no ko
        hit_valid = 1'b1; tick(); hit_valid = 1'b0;
        tick();
        chk("kb2_state", state_out, 2'd1);
        do_reset();
        ko_cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); ko_cnt += int'(ko_pulse); end
        chk("abort_no_ko", 2'(ko_cnt), 2'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            int x, y;
            x = int'($urandom_range(0, 1040)) - 200;
            y = int'($urandom_range(0, 880)) - 200;
            if ($urandom_range(0, 24) == 0) x = ($urandom_range(0, 1) == 0) ? -201 : 841;
            if ($urandom_range(0, 24) == 0) y = ($urandom_range(0, 1) == 0) ? -201 : 681;
            position   = pos(x, y);
            hit_valid  = ($urandom_range(0, 5) == 0);
            freeze_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
